// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among four users, one outstanding operation per user.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (user 0 highest).
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_USERS  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_USERS-1:0]             req_valid,
    output logic [NUM_USERS-1:0]             req_ready,
    input  logic [NUM_USERS*DATA_WIDTH-1:0]  req_A,
    input  logic [NUM_USERS*DATA_WIDTH-1:0]  req_B,
    input  logic [NUM_USERS*3-1:0]           req_ALUop,
    output logic [DATA_WIDTH-1:0]            alu_A,
    output logic [DATA_WIDTH-1:0]            alu_B,
    output logic [2:0]                       alu_ALUop,
    input  logic [DATA_WIDTH-1:0]            alu_Result,
    input  logic                             alu_Overflow,
    input  logic                             alu_CarryOut,
    input  logic                             alu_Zero,
    output logic [NUM_USERS-1:0]             rsp_valid,
    input  logic [NUM_USERS-1:0]             rsp_ready,
    output logic [NUM_USERS*DATA_WIDTH-1:0]  rsp_Result,
    output logic [NUM_USERS*3-1:0]           rsp_flags
);
    localparam int ID_W = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INFLIGHT = 2'd1,
        DONE     = 2'd2
    } user_state_e;

    user_state_e           state_q [NUM_USERS];
    user_state_e           state_d [NUM_USERS];

    logic                  op_vld_q;
    logic [DATA_WIDTH-1:0] op_a_q;
    logic [DATA_WIDTH-1:0] op_b_q;
    logic [2:0]            op_alu_op_q;
    logic [ID_W-1:0]       op_id_q;

    logic [DATA_WIDTH-1:0] rsp_result_q [NUM_USERS];
    logic [2:0]            rsp_flags_q  [NUM_USERS];

    logic [NUM_USERS-1:0]  eligible;
    logic                  grant_vld;
    logic [ID_W-1:0]       grant_id;
    logic                  handshake;

    always_comb begin
        for (int i = 0; i < NUM_USERS; i++) begin
            eligible[i] = req_valid[i] && (state_q[i] == IDLE);
        end
    end

`ifdef ALU_ARB_RR_EN
    logic [ID_W-1:0] rr_ptr_q;

    // Search starts one past the last winner and wraps through all four users.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = 1; k <= NUM_USERS; k++) begin
            if (!grant_vld && eligible[rr_ptr_q + ID_W'(k)]) begin
                grant_vld = 1'b1;
                grant_id  = rr_ptr_q + ID_W'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= ID_W'(NUM_USERS - 1);
        end else if (handshake) begin
            rr_ptr_q <= grant_id;
        end
    end
`else
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int i = NUM_USERS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant_vld = 1'b1;
                grant_id  = ID_W'(i);
            end
        end
    end
`endif

    // Reset is synchronous, so it must also mask the combinational grant.
    assign handshake = grant_vld && !rst;

    always_comb begin
        req_ready = '0;
        if (handshake) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_USERS; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE:     if (handshake && grant_id == ID_W'(i)) state_d[i] = INFLIGHT;
                INFLIGHT: if (op_vld_q && op_id_q == ID_W'(i))   state_d[i] = DONE;
                DONE:     if (rsp_ready[i])                      state_d[i] = IDLE;
                default:  state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            for (int i = 0; i < NUM_USERS; i++) begin
                state_q[i] <= IDLE;
            end
            op_vld_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_USERS; i++) begin
                state_q[i] <= state_d[i];
            end
            op_vld_q <= handshake;
        end
    end

    // NOTE: the operand stage has no reset; op_vld gates it onto the ALU port, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (handshake) begin
            op_a_q      <= req_A[grant_id*DATA_WIDTH +: DATA_WIDTH];
            op_b_q      <= req_B[grant_id*DATA_WIDTH +: DATA_WIDTH];
            op_alu_op_q <= req_ALUop[grant_id*3 +: 3];
            op_id_q     <= grant_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_USERS; i++) begin
                rsp_result_q[i] <= '0;
                rsp_flags_q[i]  <= '0;
            end
        end else if (op_vld_q) begin
            rsp_result_q[op_id_q] <= alu_Result;
            rsp_flags_q[op_id_q]  <= {alu_Overflow, alu_CarryOut, alu_Zero};
        end
    end

    assign alu_A     = op_vld_q ? op_a_q      : '0;
    assign alu_B     = op_vld_q ? op_b_q      : '0;
    assign alu_ALUop = op_vld_q ? op_alu_op_q : 3'b000;

    always_comb begin
        rsp_valid  = '0;
        rsp_Result = '0;
        rsp_flags  = '0;
        for (int i = 0; i < NUM_USERS; i++) begin
            rsp_valid[i]                            = (state_q[i] == DONE);
            rsp_Result[i*DATA_WIDTH +: DATA_WIDTH] = rsp_result_q[i];
            rsp_flags[i*3 +: 3]                     = rsp_flags_q[i];
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised scoreboard bench for alu_arbiter with a behavioural ALU and a cycle-level user model.
// Follows ALU_ARB_RR_EN to pick the expected arbitration policy.
module tb_alu_arbiter;
    localparam int DW = 32;
    localparam int NU = 4;

    typedef struct packed {
        logic [2:0]  f;   // {Overflow, CarryOut, Zero}
        logic [31:0] r;
    } alu_out_t;

    logic              clk;
    logic              rst;
    logic [NU-1:0]     req_valid;
    logic [NU-1:0]     req_ready;
    logic [NU*DW-1:0]  req_A;
    logic [NU*DW-1:0]  req_B;
    logic [NU*3-1:0]   req_ALUop;
    logic [DW-1:0]     alu_A;
    logic [DW-1:0]     alu_B;
    logic [2:0]        alu_ALUop;
    logic [DW-1:0]     alu_Result;
    logic              alu_Overflow;
    logic              alu_CarryOut;
    logic              alu_Zero;
    logic [NU-1:0]     rsp_valid;
    logic [NU-1:0]     rsp_ready;
    logic [NU*DW-1:0]  rsp_Result;
    logic [NU*3-1:0]   rsp_flags;

    alu_arbiter #(.DATA_WIDTH(DW), .NUM_USERS(NU)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_A(req_A), .req_B(req_B), .req_ALUop(req_ALUop),
        .alu_A(alu_A), .alu_B(alu_B), .alu_ALUop(alu_ALUop),
        .alu_Result(alu_Result), .alu_Overflow(alu_Overflow),
        .alu_CarryOut(alu_CarryOut), .alu_Zero(alu_Zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_Result(rsp_Result), .rsp_flags(rsp_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: AND, OR, ADD, SUB, SLT; any other opcode yields 0.
    function automatic alu_out_t alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        alu_out_t o;
        logic [32:0] sum;
        o = '0;
        case (op)
            3'b000: o.r = a & b;
            3'b001: o.r = a | b;
            3'b010: begin
                sum    = {1'b0, a} + {1'b0, b};
                o.r    = sum[31:0];
                o.f[1] = sum[32];
                o.f[2] = (a[31] == b[31]) && (o.r[31] != a[31]);
            end
            3'b110: begin
                o.r    = a - b;
                o.f[1] = (a < b);
                o.f[2] = (a[31] != b[31]) && (o.r[31] != a[31]);
            end
            3'b111: o.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: o.r = 32'd0;
        endcase
        o.f[0] = (o.r == 32'd0);
        return o;
    endfunction

    alu_out_t alu_env;
    always_comb alu_env = alu_fn(alu_A, alu_B, alu_ALUop);
    assign alu_Result   = alu_env.r;
    assign alu_Overflow = alu_env.f[2];
    assign alu_CarryOut = alu_env.f[1];
    assign alu_Zero     = alu_env.f[0];

    // Reference model: which users hold a slot, when their answer becomes visible, and the ALU drive.
    int          cyc = 0;
    bit          m_busy  [NU];
    int          m_avail [NU];
    int          m_ptr = NU - 1;
    logic [31:0] m_alu_a = '0;
    logic [31:0] m_alu_b = '0;
    logic [2:0]  m_alu_op = '0;
    alu_out_t    exp_q [NU][$];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // One clock of stimulus: drive, check the grant and ALU drive, then advance the model.
    task automatic step(input logic r, input logic [NU-1:0] v, input logic [NU*DW-1:0] a,
                        input logic [NU*DW-1:0] b, input logic [NU*3-1:0] op, input logic [NU-1:0] rr);
        int win;
        int now;
        logic [NU-1:0] want_ready;
        @(negedge clk);
        rst = r; req_valid = v; req_A = a; req_B = b; req_ALUop = op; rsp_ready = rr;
        #1;
        win = -1;
        if (!r) begin
`ifdef ALU_ARB_RR_EN
            for (int k = 1; k <= NU; k++) begin
                int c;
                c = (m_ptr + k) % NU;
                if (win < 0 && v[c] && !m_busy[c]) win = c;
            end
`else
            for (int c = 0; c < NU; c++) begin
                if (win < 0 && v[c] && !m_busy[c]) win = c;
            end
`endif
        end
        want_ready = '0;
        if (win >= 0) want_ready[win] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(want_ready));
        check("alu_drive", {alu_A, alu_B[28:0], alu_ALUop}, {m_alu_a, m_alu_b[28:0], m_alu_op});
        now = cyc;
        @(posedge clk);
        cyc++;
        if (r) begin
            for (int i = 0; i < NU; i++) begin
                m_busy[i] = 1'b0;
                exp_q[i].delete();
            end
            m_ptr = NU - 1;
            m_alu_a = '0; m_alu_b = '0; m_alu_op = '0;
        end else begin
            for (int i = 0; i < NU; i++) begin
                if (m_busy[i] && now >= m_avail[i] && rr[i]) m_busy[i] = 1'b0;
            end
            if (win >= 0) begin
                m_busy[win]  = 1'b1;
                m_avail[win] = now + 2;
                m_ptr        = win;
                m_alu_a      = a[win*DW +: DW];
                m_alu_b      = b[win*DW +: DW];
                m_alu_op     = op[win*3 +: 3];
                exp_q[win].push_back(alu_fn(m_alu_a, m_alu_b, m_alu_op));
            end else begin
                m_alu_a = '0; m_alu_b = '0; m_alu_op = '0;
            end
        end
    endtask

    // Monitor: compares presented responses against the scoreboard, popping on consume.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            #2;
            for (int i = 0; i < NU; i++) begin
                logic want_v;
                want_v = m_busy[i] && (cyc >= m_avail[i]);
                check($sformatf("rsp_valid[%0d]", i), 64'(rsp_valid[i]), 64'(want_v));
                if (rsp_valid[i] && want_v) begin
                    if (exp_q[i].size() == 0) begin
                        check($sformatf("rsp_queue_empty[%0d]", i), 64'(1), 64'(0));
                    end else begin
                        check($sformatf("rsp_Result[%0d]", i), 64'(rsp_Result[i*DW +: DW]), 64'(exp_q[i][0].r));
                        check($sformatf("rsp_flags[%0d]", i), 64'(rsp_flags[i*3 +: 3]), 64'(exp_q[i][0].f));
                        if (rsp_ready[i] && !rst) void'(exp_q[i].pop_front());
                    end
                end
            end
        end
    end

    function automatic logic [NU*DW-1:0] rnd_ops();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_cleared();
        check("rsp_valid_reset", 64'(rsp_valid), 64'(0));
        check("rsp_Result_reset_lo", rsp_Result[63:0], 64'(0));
        check("rsp_Result_reset_hi", rsp_Result[127:64], 64'(0));
        check("rsp_flags_reset", 64'(rsp_flags), 64'(0));
    endtask

    logic [NU*DW-1:0] a_v, b_v;
    logic [NU*3-1:0]  op_v;

    initial begin
        rst = 1'b1; req_valid = '0; req_A = '0; req_B = '0; req_ALUop = '0; rsp_ready = '0;
        for (int i = 0; i < NU; i++) begin m_busy[i] = 1'b0; m_avail[i] = 0; end
        @(posedge clk);
        cyc = 1;

        // Reset held with every user requesting: nothing may be granted.
        step(1'b1, 4'hF, '0, '0, '0, 4'hF);
        step(1'b1, 4'hF, '0, '0, '0, 4'hF);
        #2;
        check_cleared();

        // User 0 ADD 5+7.
        a_v = '0; b_v = '0; op_v = '0;
        a_v[31:0] = 32'd5; b_v[31:0] = 32'd7; op_v[2:0] = 3'b010;
        step(1'b0, 4'b0001, a_v, b_v, op_v, 4'hF);
        for (int n = 0; n < 4; n++) step(1'b0, 4'b0000, '0, '0, '0, 4'hF);

        // Four users SUB i-i, each dropping its request once accepted.
        for (int i = 0; i < NU; i++) begin
            a_v[i*DW +: DW] = DW'(i); b_v[i*DW +: DW] = DW'(i); op_v[i*3 +: 3] = 3'b110;
        end
        step(1'b0, 4'b1111, a_v, b_v, op_v, 4'hF);
        step(1'b0, 4'b1110, a_v, b_v, op_v, 4'hF);
        step(1'b0, 4'b1100, a_v, b_v, op_v, 4'hF);
        step(1'b0, 4'b1000, a_v, b_v, op_v, 4'hF);
        for (int n = 0; n < 5; n++) step(1'b0, 4'b0000, '0, '0, '0, 4'hF);

        // Signed overflow on SUB and SLT with a negative operand.
        a_v = '0; b_v = '0; op_v = '0;
        a_v[2*DW +: DW] = 32'h8000_0000; b_v[2*DW +: DW] = 32'd1; op_v[6 +: 3] = 3'b110;
        a_v[3*DW +: DW] = 32'hFFFF_FFFF; b_v[3*DW +: DW] = 32'd1; op_v[9 +: 3] = 3'b111;
        step(1'b0, 4'b1100, a_v, b_v, op_v, 4'hF);
        step(1'b0, 4'b1000, a_v, b_v, op_v, 4'hF);
        for (int n = 0; n < 4; n++) step(1'b0, 4'b0000, '0, '0, '0, 4'hF);

        // Random traffic with random backpressure.
        for (int n = 0; n < 400; n++) begin
            step(1'b0, 4'($urandom), rnd_ops(), rnd_ops(), 12'($urandom), 4'($urandom | $urandom));
        end

        // User 1 stalled on its response while others keep flowing, then released.
        for (int n = 0; n < 60; n++) begin
            step(1'b0, 4'($urandom) | 4'b0010, rnd_ops(), rnd_ops(), 12'($urandom), 4'b1101);
        end
        for (int n = 0; n < 20; n++) begin
            step(1'b0, 4'b1111, rnd_ops(), rnd_ops(), 12'($urandom), 4'hF);
        end

        // Users 0 and 3 requesting continuously with instant consume.
        for (int n = 0; n < 40; n++) begin
            step(1'b0, 4'b1001, rnd_ops(), rnd_ops(), 12'($urandom), 4'hF);
        end
        for (int n = 0; n < 4; n++) step(1'b0, 4'b0000, '0, '0, '0, 4'hF);

        // Leave stale data, then a reset one cycle after a handshake drops the op.
        a_v = rnd_ops(); b_v = rnd_ops();
        step(1'b0, 4'b0001, a_v, b_v, {4{3'b010}}, 4'h0);
        step(1'b1, 4'b1111, a_v, b_v, {4{3'b010}}, 4'h0);
        #2;
        check_cleared();
        for (int n = 0; n < 6; n++) step(1'b0, 4'b0000, '0, '0, '0, 4'hF);

        // Post-reset random burst confirms the pointer and slots restarted cleanly.
        for (int n = 0; n < 100; n++) begin
            step(1'b0, 4'($urandom), rnd_ops(), rnd_ops(), 12'($urandom), 4'($urandom | $urandom));
        end

        @(negedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
